// File: rtl/adc_pkg.sv
// Shared constants and FSM state encoding for the ADC scan sequencer.
package adc_pkg;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;
    localparam int CH_W   = 3;
    localparam int PTR_W  = CH_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK    = 3'd1,
        REQ     = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4,
        GAP     = 3'd5
    } state_t;

endpackage

// File: rtl/adc_ch_pick.sv
// Next-set-bit search: lowest enabled channel at or above the search pointer.
module adc_ch_pick
    import adc_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [CH_W-1:0]   ch
);

    // Descending walk so the lowest qualifying channel is the last one written.
    always_comb begin
        found = 1'b0;
        ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= ptr)) begin
                found = 1'b1;
                ch    = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans the enabled ADC channels in ascending order, stores each result in a
// per-channel bank and idles GAP_CYCLES between scans.
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    input  logic [7:0]        ch_mask,
    input  logic              adc_ready,
    input  logic [11:0]       d_signal,
    output logic              ctl_valid,
    output logic [2:0]        address,
    output logic              adc_ack,
    input  logic [2:0]        rd_addr,
    output logic [11:0]       rd_data,
    output logic              sample_valid,
    output logic [2:0]        sample_ch,
    output logic [11:0]       sample_data,
    output logic              scan_done,
    output logic              timeout_err,
    output logic              busy
);

    // GAP_CYCLES of 0 and 1 both give a single GAP cycle.
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W    = $clog2(GAP_LAST + 2);
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int TMO_W    = $clog2(TMO_LAST + 2);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   scan_mask;
    logic                ld_mask;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [CH_W-1:0]     addr_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [DATA_W-1:0]   bank [NUM_CH];

    logic                pick_found;
    logic [CH_W-1:0]     pick_ch;
    logic                conv_done;
    logic                tmo_hit;
    logic                gap_end;
    logic [PTR_W-1:0]    ptr_after;

    adc_ch_pick u_pick (
        .mask  (scan_mask),
        .ptr   (ptr),
        .found (pick_found),
        .ch    (pick_ch)
    );

    assign conv_done = (state == REQ) && adc_ready;
    assign tmo_hit   = (state == REQ) && !adc_ready && (tmo_cnt == TMO_W'(TMO_LAST));
    assign gap_end   = (gap_cnt == GAP_W'(GAP_LAST));
    assign ptr_after = PTR_W'(addr_q) + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ld_mask   = 1'b0;
        case (state)
            IDLE: begin
                if (scan_en && (ch_mask != '0)) begin
                    ld_mask   = 1'b1;
                    ptr_nxt   = '0;
                    state_nxt = PICK;
                end
            end
            PICK: begin
                state_nxt = pick_found ? REQ : GAP;
            end
            REQ: begin
                if (adc_ready) begin
                    state_nxt = ACK;
                end else if (tmo_hit) begin
                    ptr_nxt   = ptr_after;
                    state_nxt = scan_en ? PICK : IDLE;
                end
            end
            ACK: begin
                state_nxt = RELEASE;
            end
            // Converter must drop ready before the next request goes out.
            RELEASE: begin
                if (!adc_ready) begin
                    ptr_nxt   = ptr_after;
                    state_nxt = scan_en ? PICK : IDLE;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_mask   <= '0;
            ptr         <= '0;
            addr_q      <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (ld_mask) begin
                scan_mask <= ch_mask;
            end
            ptr <= ptr_nxt;
            if ((state == PICK) && pick_found) begin
                addr_q <= pick_ch;
            end
            tmo_cnt <= (state == REQ) ? tmo_cnt + TMO_W'(1) : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank[i] <= '0;
            end
        end else if (conv_done) begin
            bank[addr_q] <= d_signal;
        end
    end

    assign ctl_valid    = (state == REQ);
    assign adc_ack      = (state == ACK);
    assign busy         = (state != IDLE);
    assign scan_done    = (state == PICK) && !pick_found;
    assign address      = addr_q;
    assign sample_valid = conv_done;
    assign sample_ch    = conv_done ? addr_q : '0;
    assign sample_data  = conv_done ? d_signal : '0;
    assign rd_data      = bank[rd_addr];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a hand-driven converter model.
module tb_adc_scan_sequencer;

    localparam int GAP = 4;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        adc_ready = 1'b0;
    logic [11:0] d_signal = 12'h000;
    logic [2:0]  rd_addr = 3'd0;
    logic        ctl_valid;
    logic [2:0]  address;
    logic        adc_ack;
    logic [11:0] rd_data;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic        scan_done;
    logic        timeout_err;
    logic        busy;

    adc_scan_sequencer #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .ch_mask      (ch_mask),
        .adc_ready    (adc_ready),
        .d_signal     (d_signal),
        .ctl_valid    (ctl_valid),
        .address      (address),
        .adc_ack      (adc_ack),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .scan_done    (scan_done),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int n_sv = 0, n_done = 0, n_ctl = 0, n_ack = 0, n_busy = 0;
    int ack_run = 0, ack_max = 0;
    logic [2:0]  sv_ch  [64];
    logic [11:0] sv_dat [64];

    always @(negedge clk) begin
        if (sample_valid) begin
            sv_ch[n_sv % 64]  = sample_ch;
            sv_dat[n_sv % 64] = sample_data;
            n_sv++;
        end
        if (scan_done) n_done++;
        if (ctl_valid) n_ctl++;
        if (busy) n_busy++;
        if (adc_ack) begin
            n_ack++;
            ack_run++;
        end else begin
            ack_run = 0;
        end
        if (ack_run > ack_max) ack_max = ack_run;
    end

    task automatic chk(input string tag, input int obs, input int want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ctl(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ctl_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_req_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (scan_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 32'(ok), 1);
    endtask

    // Wait for a request, answer after dly cycles, keep ready high for hold
    // cycles after the acknowledge.
    task automatic respond(input string tag, input int exp_ch, input int dly,
                           input logic [11:0] data, input int hold, input bit drop_en);
        bit bad;
        wait_ctl(tag);
        chk({tag, "_addr"}, 32'(address), exp_ch);
        if (drop_en) scan_en = 1'b0;
        repeat (dly) tick();
        rd_addr   = 3'(exp_ch);
        adc_ready = 1'b1;
        d_signal  = data;
        tick();
        chk({tag, "_ack"}, 32'(adc_ack), 1);
        chk({tag, "_bank"}, 32'(rd_data), 32'(data));
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (ctl_valid) bad = 1'b1;
            tick();
        end
        if (ctl_valid) bad = 1'b1;
        adc_ready = 1'b0;
        d_signal  = 12'h000;
        if (hold > 0) chk({tag, "_no_req_while_ready"}, 32'(bad), 0);
    endtask

    initial begin
        int b_sv, b_done, b_ctl, b_ack, b_busy, k;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ctl_valid", 32'(ctl_valid), 0);
        chk("rst_adc_ack", 32'(adc_ack), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // Two-channel scan, then scan-to-scan latency, then mid-scan stop
        b_sv = n_sv; b_done = n_done;
        ch_mask = 8'h05;
        scan_en = 1'b1;
        respond("t1_ch0", 0, 20, 12'h100, 0, 1'b0);
        respond("t1_ch2", 2, 20, 12'h102, 0, 1'b0);
        wait_done("t1", 50);
        rd_addr = 3'd0; #1;
        chk("t1_bank0", 32'(rd_data), 32'h100);
        rd_addr = 3'd2; #1;
        chk("t1_bank2", 32'(rd_data), 32'h102);
        rd_addr = 3'd1; #1;
        chk("t1_bank1", 32'(rd_data), 0);
        k = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            k++;
            if (ctl_valid) break;
        end
        chk("t1_done_to_req", k, GAP + 3);
        chk("t1_n_samples", n_sv - b_sv, 2);
        chk("t1_s0_ch", 32'(sv_ch[b_sv % 64]), 0);
        chk("t1_s0_data", 32'(sv_dat[b_sv % 64]), 32'h100);
        chk("t1_s1_ch", 32'(sv_ch[(b_sv + 1) % 64]), 2);
        chk("t1_s1_data", 32'(sv_dat[(b_sv + 1) % 64]), 32'h102);
        chk("t1_n_done", n_done - b_done, 1);
        respond("t1_stop", 0, 3, 12'h3AA, 0, 1'b1);
        repeat (6) tick();
        chk("t1_stop_idle", 32'(busy), 0);
        chk("t1_stop_no_done", n_done - b_done, 1);
        chk("t1_stop_samples", n_sv - b_sv, 3);
        chk("t1_ack_width", ack_max, 1);

        // Converter never answers on channel 7
        b_sv = n_sv; b_done = n_done; b_ctl = n_ctl;
        ch_mask = 8'h80;
        scan_en = 1'b1;
        wait_ctl("t2");
        chk("t2_addr", 32'(address), 7);
        wait_done("t2", TMO + 20);
        scan_en = 1'b0;
        repeat (8) tick();
        chk("t2_ctl_cycles", n_ctl - b_ctl, TMO);
        chk("t2_timeout_err", 32'(timeout_err), 1);
        chk("t2_no_sample", n_sv - b_sv, 0);
        chk("t2_n_done", n_done - b_done, 1);
        rd_addr = 3'd7; #1;
        chk("t2_bank7", 32'(rd_data), 0);
        chk("t2_idle", 32'(busy), 0);

        // Empty mask never starts a scan
        b_busy = n_busy; b_ctl = n_ctl;
        ch_mask = 8'h00;
        scan_en = 1'b1;
        repeat (20) tick();
        chk("t3_busy_cycles", n_busy - b_busy, 0);
        chk("t3_ctl_cycles", n_ctl - b_ctl, 0);
        chk("t3_timeout_sticky", 32'(timeout_err), 1);
        scan_en = 1'b0;

        // Full mask, long ready hold on ch1, mask change ignored, stop on ch3
        b_sv = n_sv; b_done = n_done; b_ack = n_ack;
        ch_mask = 8'hFF;
        scan_en = 1'b1;
        respond("t4_ch0", 0, 2, 12'h200, 0, 1'b0);
        ch_mask = 8'h01;
        respond("t4_ch1", 1, 2, 12'h201, 5, 1'b0);
        respond("t4_ch2", 2, 1, 12'h202, 0, 1'b0);
        respond("t4_ch3", 3, 3, 12'h203, 0, 1'b1);
        repeat (20) tick();
        chk("t4_n_samples", n_sv - b_sv, 4);
        chk("t4_last_ch", 32'(sv_ch[(b_sv + 3) % 64]), 3);
        chk("t4_last_data", 32'(sv_dat[(b_sv + 3) % 64]), 32'h203);
        chk("t4_n_ack", n_ack - b_ack, 4);
        chk("t4_no_done", n_done - b_done, 0);
        chk("t4_idle", 32'(busy), 0);
        rd_addr = 3'd4; #1;
        chk("t4_bank4", 32'(rd_data), 0);
        chk("t4_ack_width", ack_max, 1);

        // Reset in the middle of a ch1 request
        ch_mask = 8'h02;
        scan_en = 1'b1;
        wait_ctl("t5");
        chk("t5_addr", 32'(address), 1);
        repeat (3) tick();
        b_ack = n_ack;
        rd_addr   = 3'd3;
        adc_ready = 1'b1;
        d_signal  = 12'h555;
        rst_n     = 1'b0;
        #1;
        chk("t5_ctl_valid", 32'(ctl_valid), 0);
        chk("t5_adc_ack", 32'(adc_ack), 0);
        chk("t5_sample_valid", 32'(sample_valid), 0);
        chk("t5_sample_ch", 32'(sample_ch), 0);
        chk("t5_sample_data", 32'(sample_data), 0);
        chk("t5_scan_done", 32'(scan_done), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_timeout_err", 32'(timeout_err), 0);
        chk("t5_address", 32'(address), 0);
        chk("t5_bank3", 32'(rd_data), 0);
        tick();
        tick();
        chk("t5_no_ack", n_ack - b_ack, 0);
        adc_ready = 1'b0;
        d_signal  = 12'h000;
        scan_en   = 1'b0;
        rst_n     = 1'b1;
        repeat (3) tick();
        chk("t5_idle_after", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
